// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register-file word-line logic.
//   rf_clr_state_t : clear-sequencer state (IDLE / CLEAR)
//   rf_depth()     : number of word-lines for a given address width
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_clr_state_t;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_wordline_decoder_onehot.sv
// onehot_decoder
//   Purely combinational address-to-one-hot decoder.
//   in  [ADDR_W]        : address to decode
//   en                  : when 0 the output is all zeros
//   out [2**ADDR_W]     : one-hot word-line vector
module onehot_decoder
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]           in,
    input  logic                        en,
    output logic [rf_depth(ADDR_W)-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wordline_decoder.sv
// regfile_wordline_decoder
//   Registered write word-line decoder with a built-in clear sweep that
//   walks every word-line once (after reset and/or on request).
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   wr_addr   : write address
//   wr_en     : write request
//   clr_req   : clear-sweep request
//   out       : registered one-hot word-line vector (at most one bit set)
//   busy      : high while a sweep is in progress (decoded from state)
//   clr_done  : one-cycle pulse as a sweep finishes
//   wr_drop   : one-cycle pulse when a write request was ignored
module regfile_wordline_decoder
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter bit          ZERO_REG     = 1'b1,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic                        wr_en,
    input  logic                        clr_req,
    output logic [rf_depth(ADDR_W)-1:0] out,
    output logic                        busy,
    output logic                        clr_done,
    output logic                        wr_drop
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);
    localparam int unsigned START = ZERO_REG ? 1 : 0;
    // One extra bit so the counter can reach DEPTH without wrapping.
    localparam int unsigned CW    = ADDR_W + 1;

    rf_clr_state_t     r_state;
    logic [CW-1:0]     r_cnt;
    logic [DEPTH-1:0]  r_out;
    logic              r_clr_done;
    logic              r_wr_drop;

    logic              w_in_clear;
    logic              w_start_clr;
    logic              w_sweep_end;
    logic              w_zero_hit;
    logic [ADDR_W-1:0] w_dec_addr;
    logic              w_dec_en;
    logic [DEPTH-1:0]  w_dec_out;

    assign w_in_clear  = (r_state == CLEAR);
    assign w_start_clr = !w_in_clear && clr_req;
    assign w_sweep_end = w_in_clear && (r_cnt == CW'(DEPTH));
    assign w_zero_hit  = ZERO_REG && (wr_addr == '0);

    // r_cnt is parked at START whenever the FSM is idle, so a sweep that
    // starts this cycle can decode straight from the counter.
    assign w_dec_addr = (w_in_clear || w_start_clr) ? r_cnt[ADDR_W-1:0] : wr_addr;
    assign w_dec_en   = w_in_clear ? !w_sweep_end
                                   : (w_start_clr || (wr_en && !w_zero_hit));

    onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .in  (w_dec_addr),
        .en  (w_dec_en),
        .out (w_dec_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CLR_ON_RESET ? CLEAR : IDLE;
            r_cnt      <= CW'(START);
            r_out      <= '0;
            r_clr_done <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_out      <= w_dec_out;
            r_clr_done <= w_sweep_end;
            // Writes lose to an in-progress or starting sweep.
            r_wr_drop  <= wr_en && (w_in_clear || clr_req);
            unique case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= CW'(START + 1);
                    end
                end
                CLEAR: begin
                    if (w_sweep_end) begin
                        r_state <= IDLE;
                        r_cnt   <= CW'(START);
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= CW'(START);
                end
            endcase
        end
    end

    assign out      = r_out;
    assign busy     = w_in_clear;
    assign clr_done = r_clr_done;
    assign wr_drop  = r_wr_drop;

endmodule

// File: doc/regfile_wordline_decoder.md
# regfile_wordline_decoder

Parametrised, registered write word-line decoder for the register file. It is the clocked successor of the 2-to-4 gate-level decoder. It turns an `ADDR_W`-bit write address plus write enable into a one-hot word-line vector with one cycle of latency. It also contains a clear sequencer that walks every word-line, one per cycle, so the register file can be zeroed after reset or on request. It sits between the write-port control and the register-file word enables.

## Interface
- `ADDR_W`, default 5: address width; `DEPTH = 2**ADDR_W` word-lines; legal range 1..6.
- `ZERO_REG`, default 1: when 1, word-line 0 never asserts (hardwired-zero register).
- `CLR_ON_RESET`, default 1: when 1, a clear sweep starts automatically when reset is released.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_addr` in `ADDR_W`: write address.
- `wr_en` in 1: write request, sampled every edge.
- `clr_req` in 1: clear request, sampled every edge.
- `out` out `DEPTH`: registered word-line vector; at most one bit set.
- `busy` out 1: high while a clear sweep is in progress.
- `clr_done` out 1: registered one-cycle pulse when a sweep ends.
- `wr_drop` out 1: registered one-cycle pulse when a `wr_en` was ignored.

## Operation
- **States:** `IDLE` and `CLEAR`. `busy` is 1 exactly when the state is `CLEAR`.
- **Start index:** `START = ZERO_REG ? 1 : 0`.
- **IDLE, no `clr_req`:**
  - Next `out = wr_en ? onehot(wr_addr) : 0`.
  - If `ZERO_REG` and `wr_addr == 0`, next `out = 0` and `wr_drop` stays 0 (a write to register 0 is silently discarded).
- **IDLE with `clr_req` (also when `wr_en` is high):**
  - Clear wins.
  - Next `out = onehot(START)`, `cnt <= START+1`, state becomes `CLEAR`.
  - If `wr_en` was also high, `wr_drop` pulses.
- **CLEAR:**
  - Each edge: `out <= onehot(cnt)`, `cnt <= cnt+1`.
  - After `out` has shown index `DEPTH-1`, the next edge sets `out <= 0`, pulses `clr_done`, and returns the state to `IDLE`.
  - `cnt` never wraps.
  - `clr_req` during `CLEAR` is ignored; the sweep does not restart.
  - `wr_en` during `CLEAR` is dropped, and `wr_drop` pulses on the following cycle.
- **Edge case:** `DEPTH-START == 1` (`ADDR_W=1`, `ZERO_REG=1`) gives a one-cycle sweep.
- **Reset (asynchronous, also mid-sweep):**
  - `out=0`, `clr_done=0`, `wr_drop=0`, `cnt=START`.
  - State is `CLEAR` if `CLR_ON_RESET`, else `IDLE`. So `busy` resets to `CLR_ON_RESET`.
  - Reset during a sweep aborts it. With `CLR_ON_RESET=1` a fresh sweep runs from `START`; `clr_done` is not pulsed for the aborted sweep.
- **Auto-clear after reset:** the first edge after release drives `out=onehot(START)`, and the sweep proceeds as above.

## Timing
- **Write latency:** 1 cycle. `wr_en`/`wr_addr` sampled at edge k; `out` is valid after edge k until edge k+1.
- **Sweep started at edge k:**
  - `out = onehot(START+i)` after edge k+i, for i = 0..`DEPTH-1-START`.
  - `busy` is high from after edge k until `clr_done` rises.
  - `clr_done` is high for exactly one cycle after edge `k+DEPTH-START`, with `out=0`.
  - Writes are accepted from that same edge onward.
- **Sweep duration:** `DEPTH-START` word-line cycles plus one idle-return cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs except `busy`, which is decoded from the state register only.

## Structure
- **Shared package `regfile_pkg`:** the state enum `rf_clr_state_t {IDLE, CLEAR}` and the `DEPTH` computation as a function `rf_depth(addr_w)`.
- **Sub-module:** `onehot_decoder #(ADDR_W)`, purely combinational, `in`/`en` to `out`. Instantiate it once; its address comes from a mux of `wr_addr` and `cnt`, and its enable from the mode.
- **Top module:** holds the FSM, the counter, the output registers, and the masking.

## Test plan
- **Reset auto-clear** (defaults): release `reset_n`. `busy=1`, then `out` = bit 1, 2, … 31 on consecutive cycles, then `out=0`, `clr_done=1` for 1 cycle, `busy=0`.
- **Idle writes:** `wr_en=1` with `wr_addr` = 5, 31, 0 on consecutive cycles. `out` = `32'h20`, `32'h8000_0000`, `0` one cycle later each; `wr_drop` stays 0.
- **Clear/write collision:** `clr_req=1` and `wr_en=1`, `wr_addr=7` in the same `IDLE` cycle. Next cycle `out=32'h2`, `wr_drop=1`, `busy=1`; bit 7 asserts only in its sweep slot.
- **Requests during a sweep:** `clr_req` pulse mid-sweep causes no restart and `clr_done` occurs exactly once. `wr_en` mid-sweep gives `wr_drop=1` next cycle and `out` continues the sweep.
- **Reset mid-sweep:** assert `reset_n=0` while `out=32'h400`. `out=0` immediately (asynchronous); after release the sweep restarts at bit 1, with no `clr_done` for the aborted sweep.
- **Parameter corners:** `ADDR_W=2`, `ZERO_REG=0`, `CLR_ON_RESET=0`. After reset `busy=0`; `clr_req` gives `out` = 1, 2, 4, 8, then `clr_done`; the write to address 0 gives `out=4'h1`.
